// File: rtl/output_demuxer.sv
// Receive-side channel demuxer: steers tagged words into three holding
// registers, assembles frames, flags bad ids, duplicates and timeouts.
// Ports: clk, arst (async active-low), channel/input_data/input_valid in;
// output_data, channel_valid, frame_data, frame_valid, frame_count,
// bad_channel, dup_error, timeout out; err_count out with DEMUX_ERRCNT_EN.
module output_demuxer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [3:0]          channel,
  input  logic [DATA_W-1:0]   input_data,
  input  logic                input_valid,
  output logic [3*DATA_W-1:0] output_data,
  output logic [2:0]          channel_valid,
  output logic [3*DATA_W-1:0] frame_data,
  output logic                frame_valid,
  output logic [CNT_W-1:0]    frame_count,
  output logic                bad_channel,
  output logic                dup_error,
`ifdef DEMUX_ERRCNT_EN
  output logic [7:0]          err_count,
`endif
  output logic                timeout
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT);
  localparam logic [IW-1:0] ONE = IW'(1);

  logic [2:0]          seen, seen_nxt;
  logic [IW-1:0]       idle_cnt, idle_nxt, idle_inc;
  logic [2:0]          ch_bit;
  logic                valid_id;
  logic [3*DATA_W-1:0] data_nxt, fd_nxt;
  logic [2:0]          cv_nxt;
  logic                fv_nxt, bad_nxt, dup_nxt, to_nxt;
  logic [CNT_W-1:0]    fc_nxt;

  assign idle_inc = idle_cnt + ONE;

  always_comb begin
    ch_bit = 3'b000;
    unique case (channel)
      4'h1:    ch_bit = 3'b001;
      4'h2:    ch_bit = 3'b010;
      4'h3:    ch_bit = 3'b100;
      default: ch_bit = 3'b000;
    endcase
  end

  assign valid_id = input_valid & (|ch_bit);

  always_comb begin
    data_nxt = output_data;
    fd_nxt   = frame_data;
    cv_nxt   = 3'b000;
    fv_nxt   = 1'b0;
    fc_nxt   = frame_count;
    bad_nxt  = 1'b0;
    dup_nxt  = 1'b0;
    to_nxt   = 1'b0;
    seen_nxt = seen;
    idle_nxt = idle_cnt;
    if (valid_id) begin
      for (int i = 0; i < 3; i++) begin
        if (ch_bit[i]) begin
          data_nxt[i*DATA_W +: DATA_W] = input_data;
        end
      end
      cv_nxt   = ch_bit;
      idle_nxt = '0;
      if (|(seen & ch_bit)) begin
        dup_nxt = 1'b1;
      end else if ((seen | ch_bit) == 3'b111) begin
        // snapshot includes the word arriving this cycle
        fd_nxt   = data_nxt;
        fv_nxt   = 1'b1;
        fc_nxt   = frame_count + CNT_W'(1);
        seen_nxt = 3'b000;
      end else begin
        seen_nxt = seen | ch_bit;
      end
    end else begin
      bad_nxt = input_valid;
      if (seen == 3'b000) begin
        idle_nxt = '0;
      end else if (TIMEOUT > 0) begin
        if (idle_inc == TMO) begin
          to_nxt   = 1'b1;
          seen_nxt = 3'b000;
          idle_nxt = '0;
        end else begin
          idle_nxt = idle_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      output_data   <= '0;
      channel_valid <= '0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      frame_count   <= '0;
      bad_channel   <= 1'b0;
      dup_error     <= 1'b0;
      timeout       <= 1'b0;
      seen          <= 3'b000;
      idle_cnt      <= '0;
    end else begin
      output_data   <= data_nxt;
      channel_valid <= cv_nxt;
      frame_data    <= fd_nxt;
      frame_valid   <= fv_nxt;
      frame_count   <= fc_nxt;
      bad_channel   <= bad_nxt;
      dup_error     <= dup_nxt;
      timeout       <= to_nxt;
      seen          <= seen_nxt;
      idle_cnt      <= idle_nxt;
    end
  end

`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      err_count <= 8'h00;
    end else if ((bad_nxt | dup_nxt | to_nxt) && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_demuxer.sv
// Bench for output_demuxer: directed scenarios plus randomized traffic
// checked against a frame-level reference model.
module tb_output_demuxer;

  localparam int TMO = 4;

  logic        clk;
  logic        arst;
  logic [3:0]  channel;
  logic [15:0] input_data;
  logic        input_valid;
  logic [47:0] output_data;
  logic [2:0]  channel_valid;
  logic [47:0] frame_data;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        bad_channel;
  logic        dup_error;
  logic        timeout;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int compared;
  int mismatched;

  output_demuxer #(
    .DATA_W(16),
    .TIMEOUT(TMO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .arst(arst),
    .channel(channel),
    .input_data(input_data),
    .input_valid(input_valid),
    .output_data(output_data),
    .channel_valid(channel_valid),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .bad_channel(bad_channel),
    .dup_error(dup_error),
`ifdef DEMUX_ERRCNT_EN
    .err_count(err_count),
`endif
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: frame bookkeeping in plain terms
  logic [15:0] m_hold [3];
  bit          m_seen [3];
  int          m_idle;
  int          m_fc;
  int          m_err;
  logic [47:0] m_frame;
  logic [2:0]  m_cv;
  logic        m_fv, m_bad, m_dup, m_to;

  logic [110:0] obs;
  assign obs = {output_data, channel_valid, frame_data, frame_valid,
                frame_count, bad_channel, dup_error, timeout};

  function automatic logic [110:0] expv();
    return {m_hold[2], m_hold[1], m_hold[0], m_cv, m_frame, m_fv,
            8'(m_fc), m_bad, m_dup, m_to};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hold[i] = '0;
      m_seen[i] = 0;
    end
    m_idle = 0; m_fc = 0; m_err = 0; m_frame = '0;
    m_cv = '0; m_fv = 0; m_bad = 0; m_dup = 0; m_to = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] ch,
                            input logic [15:0] d);
    int k;
    bit any;
    m_cv = '0; m_fv = 0; m_bad = 0; m_dup = 0; m_to = 0;
    if (v && ch >= 1 && ch <= 3) begin
      k = int'(ch) - 1;
      m_hold[k] = d;
      m_cv[k] = 1'b1;
      m_idle = 0;
      if (m_seen[k]) begin
        m_dup = 1;
      end else begin
        m_seen[k] = 1;
        if (m_seen[0] && m_seen[1] && m_seen[2]) begin
          m_frame = {m_hold[2], m_hold[1], m_hold[0]};
          m_fv = 1;
          m_fc = (m_fc + 1) % 256;
          for (int i = 0; i < 3; i++) m_seen[i] = 0;
        end
      end
    end else begin
      if (v) m_bad = 1;
      any = m_seen[0] || m_seen[1] || m_seen[2];
      if (!any) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_to = 1;
          m_idle = 0;
          for (int i = 0; i < 3; i++) m_seen[i] = 0;
        end
      end
    end
    if ((m_bad || m_dup || m_to) && m_err < 255) m_err++;
  endtask

  task automatic drive(input logic v, input logic [3:0] ch,
                       input logic [15:0] d);
    input_valid = v;
    channel     = ch;
    input_data  = d;
    model_step(v, ch, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    input_valid = 1'b0; channel = '0; input_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (obs !== 111'd0) begin
      mismatched++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_in_order();
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), w[i]);
      compared++;
      if (channel_valid !== 3'(1 << i) || frame_valid !== (i == 2)) begin
        mismatched++;
        $display("FAIL in_order_pulse%0d got=%b/%b want=%b/%b", i,
                 channel_valid, frame_valid, 3'(1 << i), (i == 2));
      end
    end
    compared++;
    if (frame_data !== 48'h3333_2222_1111 || frame_count !== 8'd1) begin
      mismatched++;
      $display("FAIL in_order_frame got=%h/%0d want=333322221111/1",
               frame_data, frame_count);
    end
  endtask

  task automatic test_permuted();
    int fv_cnt;
    fv_cnt = 0;
    drive(1'b1, 4'h3, 16'hAAAA); fv_cnt += int'(frame_valid);
    drive(1'b1, 4'h1, 16'hBBBB); fv_cnt += int'(frame_valid);
    drive(1'b1, 4'h2, 16'hCCCC); fv_cnt += int'(frame_valid);
    compared++;
    if (frame_data !== 48'hAAAA_CCCC_BBBB || fv_cnt != 1
        || frame_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL permuted got=%h fv=%0d want=aaaaccccbbbb fv=1",
               frame_data, fv_cnt);
    end
  endtask

  task automatic test_duplicate();
    int fv_cnt;
    fv_cnt = 0;
    drive(1'b1, 4'h1, 16'h0001); fv_cnt += int'(frame_valid);
    drive(1'b1, 4'h1, 16'h0002); fv_cnt += int'(frame_valid);
    compared++;
    if (dup_error !== 1'b1 || channel_valid !== 3'b001) begin
      mismatched++;
      $display("FAIL dup_pulse got=%b/%b want=1/001",
               dup_error, channel_valid);
    end
    drive(1'b1, 4'h2, 16'h0003); fv_cnt += int'(frame_valid);
    drive(1'b1, 4'h3, 16'h0004); fv_cnt += int'(frame_valid);
    compared++;
    if (frame_data[15:0] !== 16'h0002 || fv_cnt != 1) begin
      mismatched++;
      $display("FAIL dup_frame got=%h fv=%0d want=0002 fv=1",
               frame_data[15:0], fv_cnt);
    end
  endtask

  task automatic test_bad_channel();
    logic [47:0] od;
    logic [7:0]  fc;
    od = output_data;
    fc = frame_count;
    drive(1'b1, 4'h0, 16'hDEAD);
    compared++;
    if (bad_channel !== 1'b1 || output_data !== od
        || frame_count !== fc || channel_valid !== 3'b000) begin
      mismatched++;
      $display("FAIL bad_id0 got=%b %h %0d want=1 %h %0d",
               bad_channel, output_data, frame_count, od, fc);
    end
    drive(1'b1, 4'hF, 16'hBEEF);
    compared++;
    if (bad_channel !== 1'b1 || output_data !== od || frame_count !== fc) begin
      mismatched++;
      $display("FAIL bad_idF got=%b %h %0d want=1 %h %0d",
               bad_channel, output_data, frame_count, od, fc);
    end
    drive(1'b0, 4'h0, 16'h0);
    compared++;
    if (bad_channel !== 1'b0) begin
      mismatched++;
      $display("FAIL bad_clear got=%b want=0", bad_channel);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] fc;
    fc = frame_count;
    drive(1'b1, 4'h1, 16'h5151);
    for (int i = 1; i <= TMO; i++) begin
      drive(1'b0, 4'h0, 16'h0);
      compared++;
      if (timeout !== (i == TMO)) begin
        mismatched++;
        $display("FAIL timeout_idle%0d got=%b want=%b", i, timeout, i == TMO);
      end
    end
    compared++;
    if (output_data[15:0] !== 16'h5151) begin
      mismatched++;
      $display("FAIL timeout_keep got=%h want=5151", output_data[15:0]);
    end
    drive(1'b1, 4'h2, 16'h5252);
    drive(1'b1, 4'h3, 16'h5353);
    compared++;
    if (frame_valid !== 1'b0 || frame_count !== fc) begin
      mismatched++;
      $display("FAIL timeout_noframe got=%b/%0d want=0/%0d",
               frame_valid, frame_count, fc);
    end
    drive(1'b1, 4'h1, 16'h5454);
    compared++;
    if (frame_valid !== 1'b1 || frame_data !== 48'h5353_5252_5454) begin
      mismatched++;
      $display("FAIL timeout_refill got=%b/%h want=1/535352525454",
               frame_valid, frame_data);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 4'h1, 16'h7171);
    drive(1'b1, 4'h2, 16'h7272);
    arst = 1'b0;
    model_reset();
    #1;
    compared++;
    if (obs !== 111'd0) begin
      mismatched++;
      $display("FAIL async_reset got=%h want=0", obs);
    end
    @(negedge clk);
    arst = 1'b1;
    drive(1'b1, 4'h3, 16'h7373);
    compared++;
    if (frame_valid !== 1'b0 || channel_valid !== 3'b100) begin
      mismatched++;
      $display("FAIL reset_partial got=%b/%b want=0/100",
               frame_valid, channel_valid);
    end
  endtask

  task automatic test_random();
    int r;
    logic v;
    logic [3:0] ch;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      v = (r < 8);
      if (r < 6) ch = 4'(r % 3 + 1);
      else if (r == 6) ch = 4'h0;
      else ch = 4'($urandom_range(4, 15));
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < 5; j++) begin
          drive(1'b0, 4'h0, 16'h0);
          compared++;
          if (obs !== expv()) begin
            mismatched++;
            $display("FAIL random_idle n=%0d got=%h want=%h", n, obs, expv());
          end
        end
      end
      drive(v, ch, 16'($urandom));
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL random n=%0d got=%h want=%h", n, obs, expv());
      end
    end
  endtask

  task automatic test_err_count();
`ifdef DEMUX_ERRCNT_EN
    compared++;
    if (err_count !== 8'(m_err)) begin
      mismatched++;
      $display("FAIL errcnt_pre got=%0d want=%0d", err_count, m_err);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'h0, 16'h0);
    end
    compared++;
    if (err_count !== 8'hFF) begin
      mismatched++;
      $display("FAIL errcnt_sat got=%h want=ff", err_count);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_in_order();
    test_permuted();
    test_duplicate();
    test_bad_channel();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_err_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/output_demuxer.md
Name: output_demuxer

Overview:
Receiver-side counterpart of the transmitter's channel input muxer.
- Accepts one 16-bit word per cycle, tagged with a 4-bit channel id (1..3).
- Steers each word into one of three per-channel holding registers.
- Tracks frame completion (all three channels received) and publishes a snapshot of the complete frame.
- Flags malformed traffic: bad channel id, duplicate channel within a frame, partial-frame timeout.

Parameters:
DATA_W, 16, width of one channel word; the 48-bit buses are 3*DATA_W.
TIMEOUT, 255, idle cycles allowed inside a partial frame before it is discarded; 0 disables the timeout.
CNT_W, 8, width of frame_count.

Ports:
clk  in  1  system clock, all logic on rising edge
arst  in  1  asynchronous active-low reset
channel  in  4  channel id of input_data; valid ids 4'h1..4'h3
input_data  in  DATA_W  received word
input_valid  in  1  qualifies channel/input_data for one cycle
output_data  out  3*DATA_W  live holding registers; ch1=[15:0], ch2=[31:16], ch3=[47:32]
channel_valid  out  3  one-cycle pulse, bit n-1 set when channel n is written
frame_data  out  3*DATA_W  snapshot of the last complete frame
frame_valid  out  1  one-cycle pulse when frame_data updates
frame_count  out  CNT_W  number of complete frames, wraps
bad_channel  out  1  one-cycle pulse: valid word with id 0 or 4..15
dup_error  out  1  one-cycle pulse: channel written twice in the same frame
timeout  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (arst low, asynchronous): all outputs 0, seen mask 3'b000, idle counter 0. Release is synchronous to clk.
- Latency: every output updates at the clk edge that samples input_valid=1, so results are visible one cycle after the input is presented.
- input_valid=0: data registers hold; all pulse outputs are 0.
- Valid id n in 1..3:
  - Slice n-1 of output_data <= input_data.
  - channel_valid[n-1] pulses.
  - seen[n-1] <= 1.
- Valid bad id:
  - No register change; bad_channel pulses.
  - Seen mask and idle counter unaffected, so the idle counter keeps counting.
- Duplicate (seen[n-1] already 1):
  - Word is still written (latest wins) and channel_valid pulses.
  - dup_error pulses; seen mask unchanged.
- Frame completion, when seen | new bit == 3'b111:
  - frame_data <= output_data with the current word merged in, so the incoming word appears in the snapshot.
  - frame_valid pulses in the same cycle as that channel_valid pulse.
  - frame_count increments, wrapping at 2^CNT_W.
  - Seen mask clears to 3'b000.
- Channel order is free; any permutation of 1, 2, 3 completes a frame.
- Timeout, when TIMEOUT>0:
  - Idle counter resets to 0 on any accepted valid-id word and counts while the seen mask is nonzero and no valid-id word arrives.
  - When the count reaches TIMEOUT: seen clears, timeout pulses, counter resets. output_data keeps its contents.
  - A valid-id word arriving in the same cycle as expiry takes priority: no timeout, and the word is processed normally.
- Empty mask (3'b000): idle counter held at 0; a timeout never fires.
- Reset mid-frame: partial frame lost, no pulses issued.

Optional Feature:
Macro: DEMUX_ERRCNT_EN
- Defined:
  - Adds output err_count, 8 bits, reset 0.
  - Increments once per cycle in which any of bad_channel, dup_error or timeout pulses.
  - Saturates at 8'hFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset → all outputs 0; then words ch1=16'h1111, ch2=16'h2222, ch3=16'h3333 on consecutive cycles → channel_valid 001, 010, 100; frame_valid on the third; frame_data=48'h3333_2222_1111; frame_count=1.
2. Order ch3=AAAA, ch1=BBBB, ch2=CCCC → single frame_valid on ch2 → frame_data=48'hAAAA_CCCC_BBBB.
3. ch1=0001, ch1=0002, ch2, ch3 → dup_error on the second word; frame_data[15:0]=16'h0002; exactly one frame_valid.
4. channel=0 and channel=4'hF with valid → bad_channel pulses, output_data unchanged, frame_count unchanged.
5. TIMEOUT=4: ch1 then 4 idle cycles → timeout pulses on the 4th idle edge; subsequent ch2, ch3 produce no frame; then ch1 completes a frame.
6. Assert arst low after ch1, ch2 → outputs 0 immediately; after release, ch3 alone gives no frame_valid. With DEMUX_ERRCNT_EN defined, 300 bad words → err_count=8'hFF.
